// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared state encoding, refclk-derived timing defaults and width helper
package pll_ctrl_pkg;
   typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL} state_t;
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   localparam int REFCLK_HZ          = 74_250_000;
   localparam int DEF_PLL_RST_CYCLES = 16;
   localparam int DEF_LOCK_TIMEOUT   = REFCLK_HZ / 100;
   localparam int DEF_STABLE_CYCLES  = 4096;
   localparam int DEF_MAX_RETRIES    = 3;
   localparam int DEF_CNT_W          = cnt_width(DEF_LOCK_TIMEOUT);
endpackage

// File: rtl/pll_reset_ctrl_if.sv
// pll_reset_ctrl_if: PLL control, lock status and core reset signals of the reset controller
interface pll_reset_ctrl_if;
   logic       locked;
   logic       relock_req;
   logic       pll_rst;
   logic       sys_reset;
   logic       ready;
   logic       fail;
   logic [1:0] retry_count;
   modport master (input locked, relock_req, output pll_rst, sys_reset, ready, fail, retry_count);
   modport slave (output locked, relock_req, input pll_rst, sys_reset, ready, fail, retry_count);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer with asynchronous clear
module sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] meta;
   // two-stage shift into the clk domain
   always_ff @(posedge clk or posedge rst)
      if (rst) {q, meta} <= '0;
      else {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: sequences PLL reset, waits for stable lock with retries, then releases core reset
module pll_reset_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
   parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
   parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
   parameter int CNT_W          = DEF_CNT_W
) (
   input logic              refclk,
   input logic              rst,
   pll_reset_ctrl_if.master bus
);
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRIES);
   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
   logic [1:0]       retry, retry_nx;
   logic             locked_s, pll_rst_nx, sys_reset_nx, ready_nx, fail_nx;
   sync_2ff #(.W(1)) u_lock_sync (.clk(refclk), .rst(rst), .d(bus.locked), .q(locked_s));
   assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
   assign bus.retry_count = retry;
   // state, counter, retry tally and outputs all move together on one edge
   always_ff @(posedge refclk or posedge rst)
      if (rst) begin
         state         <= PLL_RST;
         cnt           <= '0;
         retry         <= '0;
         bus.pll_rst   <= 1'b1;
         bus.sys_reset <= 1'b1;
         bus.ready     <= 1'b0;
         bus.fail      <= 1'b0;
      end else begin
         state         <= state_nx;
         cnt           <= cnt_nx;
         retry         <= retry_nx;
         bus.pll_rst   <= pll_rst_nx;
         bus.sys_reset <= sys_reset_nx;
         bus.ready     <= ready_nx;
         bus.fail      <= fail_nx;
      end
   // sequencing: lock beats timeout, any lock loss restarts the relevant window
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt_inc;
      retry_nx = retry;
      case (state)
         PLL_RST:
            if (cnt == RST_LAST) begin
               state_nx = WAIT_LOCK;
               cnt_nx   = '0;
            end
         WAIT_LOCK:
            if (locked_s) begin
               state_nx = STABLE;
               cnt_nx   = '0;
            end else if (cnt == TO_LAST) begin
               cnt_nx = '0;
               if (retry == RETRY_MAX) state_nx = FAIL;
               else begin
                  state_nx = PLL_RST;
                  retry_nx = retry + 2'd1;
               end
            end
         STABLE:
            if (!locked_s) begin
               state_nx = WAIT_LOCK;
               cnt_nx   = '0;
            end else if (cnt == ST_LAST) begin
               state_nx = RUN;
               cnt_nx   = '0;
               retry_nx = '0;
            end
         RUN:
            if (!locked_s || bus.relock_req) begin
               state_nx = PLL_RST;
               cnt_nx   = '0;
            end
         FAIL:
            if (bus.relock_req) begin
               state_nx = PLL_RST;
               cnt_nx   = '0;
               retry_nx = '0;
            end
         default: begin
            state_nx = PLL_RST;
            cnt_nx   = '0;
         end
      endcase
   end
   // outputs decoded from the next state so they register alongside it
   always_comb begin
      pll_rst_nx   = state_nx == PLL_RST;
      sys_reset_nx = state_nx != RUN;
      ready_nx     = state_nx == RUN;
      fail_nx      = state_nx == FAIL;
   end
endmodule

// File: doc/pll_reset_ctrl.md
Name: pll_reset_ctrl

Overview:
Control-side partner of the core PLL. It drives the PLL reset, consumes the PLL locked flag, and times out and retries a failed lock. It releases the game-core system reset only after lock has been stable for a set time. It runs on refclk (74.25 MHz, free-running before lock) and sits between the top-level user reset and the PLL / core reset tree.

Parameters:
PLL_RST_CYCLES, 16, width of each PLL reset pulse in refclk cycles (>=2)
LOCK_TIMEOUT, 742500, cycles to wait for lock after pll_rst falls (10 ms)
STABLE_CYCLES, 4096, consecutive synchronized-locked cycles required before core reset release
MAX_RETRIES, 3, PLL reset retries after the initial attempt before declaring failure
CNT_W, 20, counter width; must hold max(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)-1

Ports:
refclk  in  1  reference clock, sole clock of the block
rst  in  1  asynchronous, active-high reset
locked  in  1  PLL locked flag, asynchronous to refclk
relock_req  in  1  single-cycle request to re-run the PLL reset sequence
pll_rst  out  1  reset to PLL, active-high
sys_reset  out  1  core reset, active-high
ready  out  1  high while in RUN
fail  out  1  high while in FAIL
retry_count  out  2  retries consumed in the current sequence

Behaviour:
- Clock and reset: one clock, refclk. Reset rst is asynchronous and active-high.
- locked passes through a 2-flop synchronizer, giving locked_s. Latency is 2 refclk edges.
- All outputs are registered. Each is a pure function of the next state and is updated on the same edge as the state register.
- Reset values (asserted immediately on rst, no clock needed):
  - state=PLL_RST, cnt=0
  - pll_rst=1, sys_reset=1, ready=0, fail=0, retry_count=0
  - synchronizer flops=0
- PLL_RST: pll_rst=1, sys_reset=1. cnt increments. At cnt==PLL_RST_CYCLES-1: go to WAIT_LOCK, cnt=0.
- WAIT_LOCK: pll_rst=0, sys_reset=1. cnt increments.
  - If locked_s=1: go to STABLE, cnt=0.
  - Else if cnt==LOCK_TIMEOUT-1 and retry_count==MAX_RETRIES: go to FAIL.
  - Else if cnt==LOCK_TIMEOUT-1: retry_count+1, go to PLL_RST, cnt=0.
  - locked_s=1 wins over timeout on the same cycle.
- STABLE: pll_rst=0, sys_reset=1.
  - If locked_s=0: return to WAIT_LOCK, cnt=0. This is a fresh timeout window; retry_count is unchanged.
  - Else if cnt==STABLE_CYCLES-1: go to RUN.
- RUN: sys_reset=0, ready=1. retry_count is cleared on entry.
  - If locked_s=0 or relock_req=1: go to PLL_RST, cnt=0.
  - sys_reset=1 on that same edge. Worst case: 3 refclk edges after locked falls.
- FAIL: pll_rst=0, sys_reset=1, fail=1. Exit only on relock_req (to PLL_RST, retry_count=0, cnt=0) or rst.
- relock_req is ignored in PLL_RST, WAIT_LOCK and STABLE.
- Counter saturates; it is never allowed to wrap. All compares are unsigned at CNT_W. retry_count saturates at MAX_RETRIES.
- rst asserted mid-sequence aborts immediately to the reset values. The sequence restarts from PLL_RST on the first edge after rst deasserts.
- sys_reset never deasserts unless locked_s has been 1 for STABLE_CYCLES consecutive cycles.
- pll_rst and sys_reset are glitch-free.

Decomposition:
- Shared package pll_ctrl_pkg:
  - state enum {PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL}
  - default timing constants derived from the 74.25 MHz refclk
  - clog2-based width helper
- Sub-module sync_2ff: generic 2-flop synchronizer, reset to 0, reusable across domains. Instantiated once for locked.

Test Plan:
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Nominal lock: release rst; raise locked 10 cycles after pll_rst falls -> pll_rst high for exactly 4 cycles; sys_reset falls 2+8 edges after locked rises (+1 entry edge); ready=1; retry_count=0.
2. Lock timeout: hold locked=0 -> 3 pll_rst pulses of 4 cycles, separated by 32-cycle waits; then fail=1, retry_count=2, sys_reset=1, pll_rst=0 indefinitely.
3. Glitch during STABLE: drop locked for 3 cycles at STABLE cnt=5 -> return to WAIT_LOCK; sys_reset stays 1 until 8 consecutive locked_s cycles follow relock.
4. Loss in RUN: drop locked -> sys_reset=1 and ready=0 within 3 edges; 4-cycle pll_rst pulse; normal re-sequence.
5. relock_req: a 1-cycle pulse in RUN, and separately in FAIL -> both restart from PLL_RST with retry_count=0. The same pulse during WAIT_LOCK has no effect.
6. Async rst mid-STABLE, asserted between clock edges -> pll_rst=1, sys_reset=1, ready=0 before the next edge; after release, pll_rst stays high for exactly 4 cycles.
